// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter_if                                               |
// | Brief   : Requester and serializer handshake bundle for uart_tx_arbiter.   |
// |           I_lock exists only when UART_ARB_LOCK_EN is defined.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   I_req;
    logic [8*NUM_REQ-1:0] I_data;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   I_lock;
`endif
    logic [NUM_REQ-1:0]   O_ack;
    logic [7:0]           O_tx_data;
    logic                 O_tx_exec;
    logic                 I_tx_ready;
    logic                 O_busy;
    logic [GW-1:0]        O_grant_id;
    logic                 O_error;

    // Environment side: requesters plus the uart_tx ready line
    modport master (
`ifdef UART_ARB_LOCK_EN
        output I_lock,
`endif
        output I_req, I_data, I_tx_ready,
        input  O_ack, O_tx_data, O_tx_exec, O_busy, O_grant_id, O_error
    );

    modport slave (
`ifdef UART_ARB_LOCK_EN
        input  I_lock,
`endif
        input  I_req, I_data, I_tx_ready,
        output O_ack, O_tx_data, O_tx_exec, O_busy, O_grant_id, O_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                                  |
// | Brief   : Round-robin sharing of one uart_tx among NUM_REQ byte producers. |
// |           Define UART_ARB_LOCK_EN for per-requester grant locking.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input wire             I_clk,
    input wire             I_reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int unsigned c_NUM_REQ = NUM_REQ;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_BUSY = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;

    localparam logic [7:0]         c_TIMEOUT = 8'(BUSY_TIMEOUT);
    localparam logic [NUM_REQ-1:0] c_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [7:0]         r_cnt;
    logic [GW-1:0]      r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [7:0]         r_tx_data;
    logic               r_tx_exec;
    logic               r_error;

    logic               w_found;
    logic [GW-1:0]      w_win;

    function automatic logic [GW-1:0] f_next(input logic [GW-1:0] base, input int unsigned off);
        int unsigned v_sum;
        v_sum = 32'(base) + off;
        if (v_sum >= c_NUM_REQ) v_sum = v_sum - c_NUM_REQ;
        return v_sum[GW-1:0];
    endfunction

    // Search starts one past the last grant so the last winner has lowest priority
    always_comb begin
        w_found = 1'b0;
        w_win   = r_grant;
        for (int unsigned k = 1; k <= c_NUM_REQ; k++) begin
            if (!w_found && bus.I_req[f_next(r_grant, k)]) begin
                w_found = 1'b1;
                w_win   = f_next(r_grant, k);
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (bus.I_lock[r_grant] && bus.I_req[r_grant]) begin
            w_found = 1'b1;
            w_win   = r_grant;
        end
`endif
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 8'd0;
            r_grant   <= GW'(NUM_REQ - 1);
            r_ack     <= '0;
            r_tx_data <= 8'd0;
            r_tx_exec <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_tx_exec <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.I_tx_ready && w_found) begin
                        r_tx_data <= bus.I_data[{w_win, 3'b000} +: 8];
                        r_tx_exec <= 1'b1;
                        r_ack     <= c_ONE << w_win;
                        r_grant   <= w_win;
                        r_cnt     <= 8'd0;
                        r_state   <= c_WAIT_BUSY;
                    end
                end
                c_WAIT_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (!bus.I_tx_ready) begin
                        r_state <= c_WAIT_DONE;
                    end else if (r_cnt + 8'd1 == c_TIMEOUT) begin
                        // Serializer never took the byte; it is lost, requester already acked
                        r_error <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                c_WAIT_DONE: begin
                    if (bus.I_tx_ready) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.O_ack      = r_ack;
    assign bus.O_tx_data  = r_tx_data;
    assign bus.O_tx_exec  = r_tx_exec;
    assign bus.O_busy     = (r_state != c_IDLE);
    assign bus.O_grant_id = r_grant;
    assign bus.O_error    = r_error;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx_arbiter                                               |
// | Brief   : Self-checking bench for uart_tx_arbiter (UART_ARB_LOCK_EN aware). |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 15;
    localparam int M_NORMAL = 0, M_STUCK = 1, M_BUSY = 2;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_data;
        int          exp_grant;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_v = '0;
    logic [3:0]  lock_v = '0;
    logic [31:0] data_v = '0;
    logic        ready_v = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    // serializer model
    int ser_mode = M_NORMAL;
    int ser_cnt  = 0;
    int frame_len = 10;
    logic [7:0] sent_q[$];
    int         grant_q[$];

    // reference model
    int         m_last;
    bit         m_active, m_low, m_err, m_exec;
    int         m_age;
    logic [7:0] m_data;
    logic [3:0] m_ack;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .I_clk  (clk),
        .I_reset(rst),
        .bus    (bus)
    );

    assign bus.I_req      = req_v;
    assign bus.I_data     = data_v;
    assign bus.I_tx_ready = ready_v;
`ifdef UART_ARB_LOCK_EN
    assign bus.I_lock     = lock_v;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick();
`ifdef UART_ARB_LOCK_EN
        if (lock_v[m_last] && req_v[m_last]) return m_last;
`endif
        for (int k = 1; k <= NUM_REQ; k++)
            if (req_v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = NUM_REQ - 1; m_active = 0; m_low = 0; m_err = 0;
        m_exec = 0; m_age = 0; m_data = 8'h00; m_ack = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as sampled at that edge
    task automatic model_step();
        int w;
        m_ack = '0; m_exec = 0;
        if (rst) begin model_reset(); return; end
        if (!m_active) begin
            w = pick();
            if (ready_v && w >= 0) begin
                m_ack[w] = 1'b1; m_exec = 1; m_data = data_v[w*8 +: 8];
                m_last = w; m_active = 1; m_low = 0; m_age = 0;
            end
        end else if (!m_low) begin
            if (!ready_v) m_low = 1;
            else begin
                m_age++;
                if (m_age == BUSY_TIMEOUT) begin m_err = 1; m_active = 0; end
            end
        end else if (ready_v) begin
            m_active = 0;
        end
    endtask

    task automatic compare_all();
        chk("ack",      32'(bus.O_ack),      32'(m_ack));
        chk("exec",     32'(bus.O_tx_exec),  32'(m_exec));
        chk("tx_data",  32'(bus.O_tx_data),  32'(m_data));
        chk("busy",     32'(bus.O_busy),     32'(m_active));
        chk("grant_id", 32'(bus.O_grant_id), 32'(m_last));
        chk("error",    32'(bus.O_error),    32'(m_err));
        for (int i = 0; i < NUM_REQ; i++) if (bus.O_ack[i]) grant_q.push_back(i);
    endtask

    task automatic set_mode(input int m);
        ser_mode = m;
        case (m)
            M_STUCK: ready_v = 1'b1;
            M_BUSY:  ready_v = 1'b0;
            default: ready_v = (ser_cnt == 0);
        endcase
    endtask

    task automatic ser_step();
        if (ser_mode == M_NORMAL) begin
            if (ser_cnt > 0) ser_cnt--;
            else if (bus.O_tx_exec) begin
                sent_q.push_back(bus.O_tx_data);
                ser_cnt = frame_len;
            end
        end
        set_mode(ser_mode);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        model_step();
        compare_all();
        ser_step();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_v = '0; data_v = '0; lock_v = '0;
        ser_cnt = 0; frame_len = 10; set_mode(M_NORMAL);
        sent_q.delete(); grant_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",   32'(bus.O_ack), 32'h0);
        chk("rst_exec",  32'(bus.O_tx_exec), 32'h0);
        chk("rst_data",  32'(bus.O_tx_data), 32'h0);
        chk("rst_busy",  32'(bus.O_busy), 32'h0);
        chk("rst_grant", 32'(bus.O_grant_id), 32'(NUM_REQ - 1));
        chk("rst_error", 32'(bus.O_error), 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.O_busy && n < 100) begin tick(); n++; end
        chk("wait_idle_busy", 32'(bus.O_busy), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   n;
        int   exp_lock[5];
        int   cnt0, cnt2;
        bit   raised0;

        vecs[0] = '{4'b0001, 32'h332211A5, 4'b0001, 8'hA5, 0};
        vecs[1] = '{4'b1111, 32'h13121110, 4'b0010, 8'h11, 1};
        vecs[2] = '{4'b1001, 32'h43424140, 4'b1000, 8'h43, 3};
        vecs[3] = '{4'b0110, 32'h53525150, 4'b0010, 8'h51, 1};
        vecs[4] = '{4'b0101, 32'h63626160, 4'b0100, 8'h62, 2};
        vecs[5] = '{4'b0011, 32'h73727170, 4'b0001, 8'h70, 0};
        vecs[6] = '{4'b1000, 32'h83828180, 4'b1000, 8'h83, 3};
        vecs[7] = '{4'b1100, 32'h93929190, 4'b0100, 8'h92, 2};

        // Table: one transfer per vector, rotation carried across vectors
        do_reset();
        foreach (vecs[i]) begin
            req_v = vecs[i].req; data_v = vecs[i].data;
            tick();
            chk("tbl_ack",   32'(bus.O_ack), 32'(vecs[i].exp_ack));
            chk("tbl_exec",  32'(bus.O_tx_exec), 32'h1);
            chk("tbl_data",  32'(bus.O_tx_data), 32'(vecs[i].exp_data));
            chk("tbl_grant", 32'(bus.O_grant_id), 32'(vecs[i].exp_grant));
            req_v = '0;
            wait_idle();
        end
        chk("tbl_sent_n", 32'(sent_q.size()), 32'd8);
        foreach (vecs[i]) if (i < sent_q.size()) chk("tbl_sent", 32'(sent_q[i]), 32'(vecs[i].exp_data));

        // Fairness with all four requesters holding
        do_reset();
        data_v = 32'h13121110; req_v = 4'hF;
        n = 0;
        while (grant_q.size() < 8 && n < 500) begin tick(); n++; end
        req_v = '0;
        wait_idle();
        chk("fair_n", 32'(sent_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_q.size()) chk("fair_grant", 32'(grant_q[i]), 32'(i % 4));
            if (i < sent_q.size())  chk("fair_byte", 32'(sent_q[i]), 32'(8'h10 + i % 4));
        end

        // Timeout: ready stuck high
        do_reset();
        set_mode(M_STUCK);
        req_v = 4'b0001; data_v = 32'h000000C0;
        tick();
        chk("to_exec", 32'(bus.O_tx_exec), 32'h1);
        req_v = 4'b0010; data_v = 32'h0000C1C0;
        n = 0;
        while (!bus.O_error && n < 40) begin tick(); n++; end
        chk("to_cycles", 32'(n), 32'(BUSY_TIMEOUT));
        tick();
        chk("to_next_ack", 32'(bus.O_ack), 32'h2);
        req_v = '0;
        set_mode(M_NORMAL);
        wait_idle();
        repeat (3) tick();
        chk("to_sticky", 32'(bus.O_error), 32'h1);

        // Busy hold-off: serializer externally busy in IDLE
        do_reset();
        set_mode(M_BUSY);
        req_v = 4'b1000; data_v = 32'hD3000000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_no_ack", 32'(bus.O_ack), 32'h0);
        end
        set_mode(M_NORMAL);
        tick();
        chk("hold_ack", 32'(bus.O_ack), 32'h8);
        chk("hold_grant", 32'(bus.O_grant_id), 32'h3);
        req_v = '0;
        wait_idle();

        // Reset in the middle of a frame
        do_reset();
        req_v = 4'b0100; data_v = 32'h00E20000;
        tick();
        req_v = '0;
        repeat (5) tick();
        chk("mid_busy_before", 32'(bus.O_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_ack",   32'(bus.O_ack), 32'h0);
        chk("mid_exec",  32'(bus.O_tx_exec), 32'h0);
        chk("mid_data",  32'(bus.O_tx_data), 32'h0);
        chk("mid_busy",  32'(bus.O_busy), 32'h0);
        chk("mid_grant", 32'(bus.O_grant_id), 32'h3);
        chk("mid_error", 32'(bus.O_error), 32'h0);
        model_reset();
        ser_cnt = 0; set_mode(M_NORMAL);
        req_v = 4'b1110; data_v = 32'hF3F2F100;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("mid_first_ack", 32'(bus.O_ack), 32'h2);
        chk("mid_first_data", 32'(bus.O_tx_data), 32'hF1);
        req_v = '0;
        wait_idle();

        // Lock sequence: requester 2 sends three bytes, requester 0 two
        do_reset();
`ifdef UART_ARB_LOCK_EN
        exp_lock = '{2, 2, 2, 0, 0};
`else
        exp_lock = '{2, 0, 2, 0, 2};
`endif
        req_v = 4'b0100; lock_v = 4'b0100; data_v = 32'h00C200B0;
        cnt0 = 0; cnt2 = 0; raised0 = 0; n = 0;
        while ((req_v != 0 || bus.O_busy) && n < 600) begin
            tick(); n++;
            if (bus.O_ack[2]) begin
                cnt2++;
                if (cnt2 == 3) begin req_v[2] = 1'b0; lock_v[2] = 1'b0; end
            end
            if (bus.O_ack[0]) begin
                cnt0++;
                if (cnt0 == 2) req_v[0] = 1'b0;
            end
            if (!raised0 && grant_q.size() > 0) begin req_v[0] = 1'b1; raised0 = 1; end
        end
        chk("lock_n", 32'(grant_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < grant_q.size()) chk("lock_order", 32'(grant_q[i]), 32'(exp_lock[i]));

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            frame_len = $urandom_range(1, 12);
            if (c % 500 >= 200 && c % 500 < 250) set_mode(M_STUCK);
            else if (c % 500 >= 300 && c % 500 < 320) set_mode(M_BUSY);
            else set_mode(M_NORMAL);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_v[i] && bus.O_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) data_v[i*8 +: 8] = 8'($urandom);
                    else req_v[i] = 1'b0;
                    lock_v[i] = 1'($urandom_range(0, 1));
                end else if (!req_v[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_v[i] = 1'b1;
                        data_v[i*8 +: 8] = 8'($urandom);
                        lock_v[i] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req_v[i] = 1'b0;
                end
            end
        end
        req_v = '0;
        set_mode(M_NORMAL);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
